// File: rtl/infer_pkg.sv
// Shared definitions for the MNIST MLP inference scheduler: state
// encoding, default datapath dimensions and the abort digit code.
package infer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LAUNCH = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t FIN    = 2'd3;

  localparam int DEF_OUT_DIM = 10;
  localparam int DEF_LOGIT_W = 32;

  // Reported as predicted_digit when a run aborts; truncated to IDX_W by users.
  localparam logic [31:0] ERR_DIGIT = '1;

endpackage

// File: rtl/infer_sched_argmax_stream.sv
// Streaming argmax tracker. Watches a stream of (addr, data) logit writes
// and keeps the largest signed value seen, ties resolved to the lowest
// address. Out-of-range addresses are ignored. With no accepted write the
// result is index 0 and the most-negative value.
module argmax_stream
  import infer_pkg::*;
#(
  parameter int OUT_DIM = DEF_OUT_DIM,
  parameter int LOGIT_W = DEF_LOGIT_W,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      we,
  input  logic        [IDX_W-1:0]   addr,
  input  logic signed [LOGIT_W-1:0] data,
  output logic        [IDX_W-1:0]   idx,
  output logic signed [LOGIT_W-1:0] max_val
);

  localparam logic [IDX_W:0] OUT_DIM_L = (IDX_W+1)'(OUT_DIM);
  localparam logic signed [LOGIT_W-1:0] MOST_NEG = {1'b1, {(LOGIT_W-1){1'b0}}};

  logic                      valid_q, valid_d;
  logic        [IDX_W-1:0]   idx_q,   idx_d;
  logic signed [LOGIT_W-1:0] max_q,   max_d;
  logic                      take;

  // Decide whether this write becomes the new running maximum.
  always_comb begin
    take    = 1'b0;
    valid_d = valid_q;
    idx_d   = idx_q;
    max_d   = max_q;
    if (we && ({1'b0, addr} < OUT_DIM_L)) begin
      take = !valid_q || (data > max_q) || ((data == max_q) && (addr < idx_q));
    end
    // clear wins over a coincident write so a new run never inherits state
    if (clear) begin
      valid_d = 1'b0;
      idx_d   = '0;
      max_d   = '0;
    end else if (take) begin
      valid_d = 1'b1;
      idx_d   = addr;
      max_d   = data;
    end
  end

  // Tracker registers.
  // NOTE: nonblocking assignments in clocked blocks so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      max_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
    end
  end

  assign idx     = valid_q ? idx_q : '0;
  assign max_val = valid_q ? max_q : MOST_NEG;

endmodule

// File: rtl/infer_sched.sv
// Inference scheduler: accepts a request over req/busy/done, launches the
// FC layers one after another through start/done pulses, snoops the last
// layer's logit writes for a streaming argmax and reports the digit.
// One request arriving during a run is buffered.
// Optional feature macro: INFER_SCHED_WDOG_EN adds a per-layer watchdog
// that aborts a hung run with err=1 and predicted_digit all ones.
module infer_sched
  import infer_pkg::*;
#(
  parameter int NUM_LAYERS     = 2,
  parameter int OUT_DIM        = DEF_OUT_DIM,
  parameter int LOGIT_W        = DEF_LOGIT_W,
  parameter int IDX_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic        [IDX_W-1:0]   predicted_digit,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic [NUM_LAYERS-1:0]     layer_start,
  input  logic [NUM_LAYERS-1:0]     layer_done,
  input  logic                      logit_we,
  input  logic        [IDX_W-1:0]   logit_addr,
  input  logic signed [LOGIT_W-1:0] logit_data
);

  localparam int LI_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [LI_W-1:0] LAST_LI = LI_W'(NUM_LAYERS - 1);

  // Reject configurations that cannot work at elaboration time.
  if (NUM_LAYERS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("infer_sched: NUM_LAYERS and TIMEOUT_CYCLES must be >= 1");
  end

  state_t                    state_q, state_d;
  logic [LI_W-1:0]           li_q,    li_d;
  logic                      pend_q,  pend_d;
  // Set when layer 0 was already started straight from IDLE, so LAUNCH
  // must not pulse it a second time.
  logic                      fast_q,  fast_d;
  logic                      busy_q,  busy_d;
  logic                      done_q,  done_d;
  logic [NUM_LAYERS-1:0]     start_q, start_d;
  logic        [IDX_W-1:0]   pd_q,    pd_d;
  logic signed [LOGIT_W-1:0] ml_q,    ml_d;

  logic                      trk_clear;
  logic                      trk_en;
  logic        [IDX_W-1:0]   trk_idx;
  logic signed [LOGIT_W-1:0] trk_max;

`ifdef INFER_SCHED_WDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]           wdog_q,  wdog_d;
  logic                      abort_q, abort_d;
  logic                      err_q,   err_d;
`endif

  // Next-state and registered-output decode for the scheduler FSM.
  // NOTE: every variable gets a default at the top of the block, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    li_d      = li_q;
    pend_d    = pend_q;
    fast_d    = fast_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = '0;
    pd_d      = pd_q;
    ml_d      = ml_q;
    trk_clear = 1'b0;
    trk_en    = 1'b0;
`ifdef INFER_SCHED_WDOG_EN
    wdog_d    = wdog_q;
    abort_d   = abort_q;
    err_d     = err_q;
`endif

    // One-deep request buffer; further requests while pending are dropped.
    if (req && (state_q != IDLE)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        trk_clear = 1'b1;
        li_d      = '0;
`ifdef INFER_SCHED_WDOG_EN
        abort_d   = 1'b0;
`endif
        if (req || pend_q) begin
          state_d = LAUNCH;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
`ifdef INFER_SCHED_WDOG_EN
          // err from an aborted run stays visible until the next acceptance
          err_d   = 1'b0;
`endif
          // A fresh request starts layer 0 in the very next cycle; a
          // buffered one goes through LAUNCH like every later layer.
          if (!pend_q) begin
            start_d[0] = 1'b1;
            fast_d     = 1'b1;
          end
        end
      end

      LAUNCH: begin
        if (!fast_q) start_d = NUM_LAYERS'(1) << li_q;
        fast_d  = 1'b0;
`ifdef INFER_SCHED_WDOG_EN
        wdog_d  = '0;
`endif
        state_d = WAIT;
      end

      WAIT: begin
        // Logits matter only from the last layer; a write coincident with
        // its done pulse is still in WAIT and therefore counted.
        trk_en = (li_q == LAST_LI);
        if (layer_done[li_q]) begin
          if (li_q != LAST_LI) begin
            li_d    = li_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            state_d = FIN;
          end
        end
`ifdef INFER_SCHED_WDOG_EN
        else if (wdog_q >= WD_LAST) begin
          abort_d = 1'b1;
          state_d = FIN;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end

      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pd_d    = trk_idx;
        ml_d    = trk_max;
`ifdef INFER_SCHED_WDOG_EN
        if (abort_q) pd_d = IDX_W'(ERR_DIGIT);
        err_d   = abort_q;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Scheduler state and output registers; reset discards any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      li_q    <= '0;
      pend_q  <= 1'b0;
      fast_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= '0;
      pd_q    <= '0;
      ml_q    <= '0;
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      pend_q  <= pend_d;
      fast_q  <= fast_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
      pd_q    <= pd_d;
      ml_q    <= ml_d;
    end
  end

`ifdef INFER_SCHED_WDOG_EN
  // Watchdog counter and abort/err flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  argmax_stream #(
    .OUT_DIM (OUT_DIM),
    .LOGIT_W (LOGIT_W),
    .IDX_W   (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .clear   (trk_clear),
    .we      (trk_en && logit_we),
    .addr    (logit_addr),
    .data    (logit_data),
    .idx     (trk_idx),
    .max_val (trk_max)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign layer_start     = start_q;
  assign predicted_digit = pd_q;
  assign max_logit       = ml_q;

endmodule

// File: tb/tb_infer_sched.sv
// Directed bench for infer_sched with two behavioural FC layer models.
// Layer 1 emits a programmable logit write sequence ending just before
// (or together with) its done pulse. Build with INFER_SCHED_WDOG_EN to
// include the watchdog case.
module tb_infer_sched;

  localparam int NL = 2;
  localparam int OD = 10;
  localparam int LW = 32;
  localparam int IW = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          busy, done, err;
  logic [IW-1:0] predicted_digit;
  logic [LW-1:0] max_logit;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done;
  logic          logit_we;
  logic [IW-1:0] logit_addr;
  logic [LW-1:0] logit_data;

  infer_sched #(
    .NUM_LAYERS(NL), .OUT_DIM(OD), .LOGIT_W(LW), .IDX_W(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .done(done), .err(err),
    .predicted_digit(predicted_digit), .max_logit(max_logit),
    .layer_start(layer_start), .layer_done(layer_done),
    .logit_we(logit_we), .logit_addr(logit_addr), .logit_data(logit_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- layer models ----------------
  int lat0 = 100, lat1 = 20;
  bit hang0 = 0, spur1 = 0, incl_last = 0;
  int nwr = 0;
  logic [IW-1:0] wr_addr[16];
  logic [LW-1:0] wr_data[16];
  int cnt0 = 0, cnt1 = 0;
  int t_ld0 = 0, t_ld1 = 0;

  always @(negedge clk) begin
    int c, j;
    layer_done = '0;
    logit_we   = 1'b0;
    logit_addr = '0;
    logit_data = '0;
    if (rst) begin
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      if (layer_start[0]) cnt0 = lat0;
      else if (cnt0 > 0) begin
        cnt0--;
        if (cnt0 == 0 && !hang0) begin layer_done[0] = 1'b1; t_ld0 = cyc; end
        if (spur1 && cnt0 == lat0 / 2) layer_done[1] = 1'b1;
      end
      if (layer_start[1]) cnt1 = lat1;
      else if (cnt1 > 0) begin
        cnt1--;
        if (cnt1 == 0) begin layer_done[1] = 1'b1; t_ld1 = cyc; end
        c = incl_last ? cnt1 : cnt1 - 1;
        if (c >= 0 && c < nwr) begin
          j = nwr - 1 - c;
          logit_we   = 1'b1;
          logit_addr = wr_addr[j];
          logit_data = wr_data[j];
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  int n_start0 = 0, n_start1 = 0, n_done = 0;
  int t_start0[4], t_start1[4], t_done[4];
  logic busy_at_done;

  always @(negedge clk) begin
    if (!rst) begin
      if (layer_start[0]) begin t_start0[n_start0 % 4] = cyc; n_start0++; end
      if (layer_start[1]) begin t_start1[n_start1 % 4] = cyc; n_start1++; end
      if (done) begin t_done[n_done % 4] = cyc; busy_at_done = busy; n_done++; end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_req();
    req = 1'b1; tick(); req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin tick(); k++; end
    if (n_done < target) check("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic load_normal();
    logic [LW-1:0] v[10] = '{32'd5, -32'sd3, 32'd9, 32'd9, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, -32'sd1};
    for (int i = 0; i < 10; i++) begin wr_addr[i] = IW'(i); wr_data[i] = v[i]; end
    nwr = 10; incl_last = 0;
  endtask

  int b_s0, b_s1, b_d, r_cyc, k;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0;
    tick(2);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_err",   32'(err), 0);
    check("rst_start", 32'(layer_start), 0);
    check("rst_digit", 32'(predicted_digit), 0);
    check("rst_max",   max_logit, 0);
    rst = 1'b0;
    tick(2);

    // Normal run: ties 9/9 at addr 2/3 resolve to 2.
    load_normal();
    b_s0 = n_start0; b_s1 = n_start1; b_d = n_done;
    req = 1'b1; tick(); req = 1'b0;
    check("accept_busy",  32'(busy), 1);
    check("accept_start", 32'(layer_start), 32'b01);
    wait_done(b_d + 1, 400);
    check("n1_start0", 32'(n_start0 - b_s0), 1);
    check("n1_start1", 32'(n_start1 - b_s1), 1);
    check("n1_launch_lat", 32'(t_start1[(n_start1 - 1) % 4] - t_ld0), 2);
    check("n1_done_lat",   32'(t_done[(n_done - 1) % 4] - t_ld1), 2);
    check("n1_busy_at_done", 32'(busy_at_done), 0);
    check("n1_digit", 32'(predicted_digit), 2);
    check("n1_max",   max_logit, 9);
    check("n1_err",   32'(err), 0);
    tick(5);
    check("n1_digit_held", 32'(predicted_digit), 2);

    // Descending addresses, all equal: lowest index wins.
    for (int i = 0; i < 10; i++) begin wr_addr[i] = IW'(9 - i); wr_data[i] = -32'sd7; end
    nwr = 10;
    b_d = n_done; pulse_req(); wait_done(b_d + 1, 400);
    check("rev_digit", 32'(predicted_digit), 0);
    check("rev_max",   max_logit, 32'hFFFF_FFF9);

    // Out-of-range address with a huge value is ignored.
    wr_addr[0] = 4'd0;  wr_data[0] = 32'd5;
    wr_addr[1] = 4'd12; wr_data[1] = 32'd1000;
    wr_addr[2] = 4'd3;  wr_data[2] = 32'd2;
    nwr = 3;
    b_d = n_done; pulse_req(); wait_done(b_d + 1, 400);
    check("oor_digit", 32'(predicted_digit), 0);
    check("oor_max",   max_logit, 5);

    // No logits at all.
    nwr = 0;
    b_d = n_done; pulse_req(); wait_done(b_d + 1, 400);
    check("nolog_digit", 32'(predicted_digit), 0);
    check("nolog_max",   max_logit, 32'h8000_0000);

    // Three requests during a run -> exactly one buffered inference.
    load_normal();
    b_s0 = n_start0; b_d = n_done;
    pulse_req();
    tick(5);  pulse_req();
    tick(30); pulse_req();
    tick(20); pulse_req();
    wait_done(b_d + 2, 800);
    tick(150);
    check("pend_dones",  32'(n_done - b_d), 2);
    check("pend_starts", 32'(n_start0 - b_s0), 2);
    check("pend_restart_lat", 32'(t_start0[(b_s0 + 1) % 4] - t_done[b_d % 4]), 2);
    check("pend_digit", 32'(predicted_digit), 2);

    // Spurious layer_done[1] while layer 0 is running.
    spur1 = 1;
    b_s1 = n_start1; b_d = n_done;
    pulse_req(); wait_done(b_d + 1, 400);
    spur1 = 0;
    check("spur_start1", 32'(n_start1 - b_s1), 1);
    check("spur_launch_lat", 32'(t_start1[(n_start1 - 1) % 4] - t_ld0), 2);
    check("spur_digit", 32'(predicted_digit), 2);

    // New maximum written in the same cycle as the last layer_done.
    load_normal();
    wr_data[7] = 32'd100; nwr = 8; incl_last = 1;
    b_d = n_done; pulse_req(); wait_done(b_d + 1, 400);
    check("last_digit", 32'(predicted_digit), 7);
    check("last_max",   max_logit, 100);

    // Asynchronous reset during the layer-1 wait with a request pending.
    load_normal();
    b_s1 = n_start1;
    pulse_req();
    k = 0;
    while (n_start1 == b_s1 && k < 400) begin tick(); k++; end
    check("rst_reach_l1", 32'(n_start1 - b_s1), 1);
    tick(3); pulse_req(); tick(2);
    @(negedge clk); #2 rst = 1'b1; #1;
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_start", 32'(layer_start), 0);
    check("mid_rst_digit", 32'(predicted_digit), 0);
    check("mid_rst_max",   max_logit, 0);
    check("mid_rst_done",  32'(done), 0);
    check("mid_rst_err",   32'(err), 0);
    tick(2); rst = 1'b0; tick(2);
    b_s0 = n_start0; b_d = n_done;
    pulse_req(); wait_done(b_d + 1, 400);
    tick(150);
    check("post_rst_dones",  32'(n_done - b_d), 1);
    check("post_rst_starts", 32'(n_start0 - b_s0), 1);
    check("post_rst_digit",  32'(predicted_digit), 2);

`ifdef INFER_SCHED_WDOG_EN
    // Layer 0 hangs: watchdog aborts after TIMEOUT_CYCLES in WAIT.
    hang0 = 1;
    b_d = n_done; r_cyc = cyc;
    pulse_req(); wait_done(b_d + 1, 200);
    hang0 = 0;
    check("wdog_err",   32'(err), 1);
    check("wdog_digit", 32'(predicted_digit), 15);
    check("wdog_lat_ok", 32'((t_done[(n_done - 1) % 4] - r_cyc) inside {[50:56]}), 1);
    tick(3);
    b_d = n_done; pulse_req();
    check("wdog_err_cleared", 32'(err), 0);
    wait_done(b_d + 1, 400);
    check("wdog_next_err",   32'(err), 0);
    check("wdog_next_digit", 32'(predicted_digit), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/infer_sched.md
# infer_sched

Inference scheduler for the MNIST MLP datapath. It accepts inference requests through a req/busy/done handshake and sequences the FC layer engines through their start/done pulses, first to last. It snoops the last layer's logit write port to compute a streaming argmax, then reports the predicted digit. It replaces the free-running auto-start sequencer in the top level and buffers one request that arrives while an inference is running.

## Interface
- NUM_LAYERS, 2, number of chained FC layers (≥1)
- OUT_DIM, 10, logits produced by the last layer
- LOGIT_W, 32, signed logit width
- IDX_W, 4, width of logit address / predicted index ($clog2(OUT_DIM))
- TIMEOUT_CYCLES, 65535, per-layer watchdog limit (used only with the watchdog macro)

Ports:
- clk  in  1  clock
- rst  in  1  reset; **one clock; reset is asynchronous and active-high**
- req  in  1  inference request, sampled each cycle
- busy  out  1  high from request acceptance until the cycle of done
- done  out  1  one-cycle pulse when a result is valid
- err  out  1  set together with done when the run aborted; held until next acceptance
- predicted_digit  out  IDX_W  argmax index; held until the next done
- max_logit  out  LOGIT_W  signed value at predicted_digit; held until the next done
- layer_start  out  NUM_LAYERS  one-hot start pulse to layer i
- layer_done  in  NUM_LAYERS  done pulse from layer i
- logit_we  in  1  last-layer output write enable (snooped)
- logit_addr  in  IDX_W  last-layer output address
- logit_data  in  LOGIT_W  last-layer output data (signed)

## Operation
- States: IDLE, LAUNCH, WAIT, FIN.
- **IDLE**
  - req, or the pending flag set → LAUNCH.
  - Clear layer index `li`, the pending flag, the argmax tracker and err.
- **LAUNCH**
  - Assert layer_start[li] for one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - Wait for layer_done[li].
  - layer_done bits for other layers are ignored.
  - On layer_done[li]: if li < NUM_LAYERS-1, increment li and go to LAUNCH; otherwise go to FIN.
- **FIN**
  - Register the tracker into predicted_digit and max_logit.
  - Pulse done.
  - Go to IDLE.
- **Pending request**
  - req while busy sets a 1-deep pending flag.
  - Further reqs while pending is set are dropped.
- **Streaming argmax**
  - Active only while li == NUM_LAYERS-1 and state is WAIT.
  - The first accepted write loads the tracker.
  - Each later write replaces it if logit_data > max (signed), or if logit_data == max and logit_addr < current index. Ties therefore resolve to the lowest index.
  - Writes with logit_addr ≥ OUT_DIM are ignored.
  - A logit_we in the same cycle as the last layer_done is included.
- **No logits written:** predicted_digit = 0 and max_logit = most-negative value.
- **Reset values:** busy 0, done 0, err 0, layer_start 0, predicted_digit 0, max_logit 0. State = IDLE, pending = 0. Reset mid-run discards all progress.

## Timing
- req high in cycle t (IDLE) → busy=1 and layer_start[0]=1 in t+1.
- layer_done[i] in cycle t → layer_start[i+1] in t+2, one cycle in LAUNCH.
- Last layer_done in t → FIN in t+1; done, predicted_digit and max_logit valid in t+2.
- busy falls in the same cycle done rises.
- With pending set, layer_start[0] follows at done+2.
- Scheduler overhead is 2 cycles per layer plus 2 cycles at the end.
- All outputs are registered.

## Configuration
- **INFER_SCHED_WDOG_EN defined:**
  - A 16-bit-or-wider counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without layer_done[li], go to FIN with err=1 and predicted_digit = all ones.
  - Later layer_done pulses from the hung layer are ignored in IDLE.
- **Not defined:** no counter exists, err is tied to 0, and WAIT waits indefinitely.

## Structure
- Package infer_pkg holds:
  - the state encoding (2-bit localparams IDLE/LAUNCH/WAIT/FIN);
  - default OUT_DIM and LOGIT_W;
  - the ERR_DIGIT constant (all ones).
- Sub-module argmax_stream holds the tracker: clear, we, addr, data in; idx and max out. Its compare rule is tested in isolation.

## Test plan
- **Normal run.** NUM_LAYERS=2. Layer models return done after 100 and 20 cycles. Last layer writes logits {5,-3,9,9,0,...} at addrs 0..9 → one layer_start[0], then one layer_start[1]; done with predicted_digit=2, max_logit=9.
- **Reverse order.** Writes in descending addr order with values all -7 → predicted_digit=0, max_logit=-7. Separate case: a write with addr=12 and data=1000 is ignored.
- **Request during busy.** Pulse req while busy, three times → exactly one extra inference; second layer_start[0] at first done+2; two done pulses total.
- **Spurious done.** layer_done[1] while waiting on layer 0 → no state change. Separate case: logit_we together with the last layer_done carrying the new max → that value wins.
- **Reset mid-run.** Assert rst during the layer-1 wait → all outputs 0 immediately (async). A post-reset req starts cleanly with no leftover pending run.
- **Watchdog (INFER_SCHED_WDOG_EN, TIMEOUT_CYCLES=50).** Layer 0 never completes → done with err=1 and predicted_digit=15 about 52 cycles after req. A following normal run clears err.
